// File: rtl/maxnet_pkg.sv
// -----------------------------------------------------------------------------
// maxnet_pkg
// Shared definitions for the MAXNET iteration sequencer:
//   - state_e        : sequencer FSM states
//   - DW_DEF         : default activation width (matches PU x/out width)
//   - N_DEF          : default lane count (fixed at 4 in this revision)
//   - ITW_DEF        : default iteration counter width
//   - MAX_ITER_DEF   : default iteration cap
//   - LANE_W         : width of a lane index
// -----------------------------------------------------------------------------
package maxnet_pkg;

    localparam int DW_DEF       = 5;
    localparam int N_DEF        = 4;
    localparam int ITW_DEF      = 8;
    localparam int MAX_ITER_DEF = 15;
    localparam int LANE_W       = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MULT   = 3'd2,
        S_SUM    = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/maxnet_if.sv
// -----------------------------------------------------------------------------
// maxnet_if
// Bundles the sequencer's run-control, PU-array and result signals.
//   start       : begin a new run (host -> controller)
//   x_in        : initial activations, one DW-bit lane each (host -> controller)
//   pu_out      : PU lane outputs (PU array -> controller)
//   pu_s        : PU lane nonzero flags (PU array -> controller)
//   pu_x        : activations fed to the PU x inputs (controller -> PU array)
//   ld_mult     : PU product-register load strobe
//   ld_sum      : PU sum-register load strobe
//   busy/done   : run status
//   winner      : winning lane index, winner_val its activation
//   no_winner   : run ended with no survivors or at the cap
//   timeout     : run ended at the iteration cap
//   iter_cnt    : iterations completed in the current or last run
// Modports: master = controller view, slave = host/PU-array view.
// -----------------------------------------------------------------------------
interface maxnet_if
    import maxnet_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int N   = N_DEF,
    parameter int ITW = ITW_DEF
) ();

    logic                      start;
    logic [N-1:0][DW-1:0]      x_in;
    logic [N-1:0][DW-1:0]      pu_out;
    logic [N-1:0]              pu_s;
    logic [N-1:0][DW-1:0]      pu_x;
    logic                      ld_mult;
    logic                      ld_sum;
    logic                      busy;
    logic                      done;
    logic [LANE_W-1:0]         winner;
    logic [DW-1:0]             winner_val;
    logic                      no_winner;
    logic                      timeout;
    logic [ITW-1:0]            iter_cnt;

    modport master (
        input  start, x_in, pu_out, pu_s,
        output pu_x, ld_mult, ld_sum, busy, done,
               winner, winner_val, no_winner, timeout, iter_cnt
    );

    modport slave (
        output start, x_in, pu_out, pu_s,
        input  pu_x, ld_mult, ld_sum, busy, done,
               winner, winner_val, no_winner, timeout, iter_cnt
    );

endinterface

// File: rtl/maxnet_winner_detect.sv
// -----------------------------------------------------------------------------
// maxnet_winner_detect
// Combinational survivor analysis of the four PU nonzero flags.
//   s_i      : lane nonzero flags
//   count_o  : number of surviving lanes (0..4)
//   onehot_o : exactly one lane survives
//   index_o  : lowest set lane index (0 when no lane is set)
// -----------------------------------------------------------------------------
module maxnet_winner_detect
    import maxnet_pkg::*;
(
    input  logic [3:0]        s_i,
    output logic [2:0]        count_o,
    output logic              onehot_o,
    output logic [LANE_W-1:0] index_o
);

    always_comb begin
        count_o = 3'(s_i[0]) + 3'(s_i[1]) + 3'(s_i[2]) + 3'(s_i[3]);
        onehot_o = (count_o == 3'd1);
        // Scan from the top so the lowest set lane is the last to win.
        index_o = '0;
        for (int i = 3; i >= 0; i--) begin
            if (s_i[i]) begin
                index_o = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/maxnet_controller.sv
// -----------------------------------------------------------------------------
// maxnet_controller
// Iteration sequencer in front of the four-lane PU array. Captures the initial
// activations, drives them to the PUs, pulses ld_mult then ld_sum, and writes
// the PU outputs back as the next activations until one lane survives, all
// lanes die, or MAX_ITER iterations have run.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : maxnet_if master modport (run control, PU strobes/data, results)
// -----------------------------------------------------------------------------
module maxnet_controller
    import maxnet_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int N        = N_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITW      = ITW_DEF
) (
    input  logic     clk,
    input  logic     rst,
    maxnet_if.master bus
);

    localparam logic [ITW-1:0] ITER_CAP = ITW'(MAX_ITER);

    state_e               state_q, state_d;
    logic [N-1:0][DW-1:0] act_q, act_d;
    logic [ITW-1:0]       iter_q, iter_d;
    logic [LANE_W-1:0]    win_q, win_d;
    logic [DW-1:0]        wval_q, wval_d;
    logic                 nw_q, nw_d;
    logic                 to_q, to_d;
    logic                 done_q, done_d;

    logic [2:0]           surv_cnt;
    logic                 surv_onehot;
    logic [LANE_W-1:0]    surv_idx;

    maxnet_winner_detect u_detect (
        .s_i      (bus.pu_s),
        .count_o  (surv_cnt),
        .onehot_o (surv_onehot),
        .index_o  (surv_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            act_q   <= '0;
            iter_q  <= '0;
            win_q   <= '0;
            wval_q  <= '0;
            nw_q    <= 1'b0;
            to_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            iter_q  <= iter_d;
            win_q   <= win_d;
            wval_q  <= wval_d;
            nw_q    <= nw_d;
            to_q    <= to_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        iter_d  = iter_q;
        win_d   = win_q;
        wval_d  = wval_q;
        nw_d    = nw_q;
        to_d    = to_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // done is registered off the DONE state, so it rises one clock
                // after the final UPDATE commits and holds until a restart.
                done_d = (state_q == S_DONE);
                if (bus.start) begin
                    act_d   = bus.x_in;
                    iter_d  = '0;
                    win_d   = '0;
                    wval_d  = '0;
                    nw_d    = 1'b0;
                    to_d    = 1'b0;
                    done_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_MULT;
            end
            S_MULT: begin
                state_d = S_SUM;
            end
            S_SUM: begin
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                act_d  = bus.pu_out;
                iter_d = iter_q + ITW'(1);
                // pu_s alone decides survivors; pu_out is taken as-is.
                if (surv_onehot) begin
                    win_d   = surv_idx;
                    wval_d  = bus.pu_out[surv_idx];
                    state_d = S_DONE;
                end else if (surv_cnt == 3'd0) begin
                    nw_d    = 1'b1;
                    state_d = S_DONE;
                end else if (iter_q + ITW'(1) == ITER_CAP) begin
                    nw_d    = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_MULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.pu_x       = act_q;
    assign bus.ld_mult    = (state_q == S_MULT);
    assign bus.ld_sum     = (state_q == S_SUM);
    assign bus.busy       = (state_q == S_LOAD) || (state_q == S_MULT) ||
                            (state_q == S_SUM)  || (state_q == S_UPDATE);
    assign bus.done       = done_q;
    assign bus.winner     = win_q;
    assign bus.winner_val = wval_q;
    assign bus.no_winner  = nw_q;
    assign bus.timeout    = to_q;
    assign bus.iter_cnt   = iter_q;

endmodule

// File: tb/tb_maxnet_controller.sv
// -----------------------------------------------------------------------------
// tb_maxnet_controller
// Scoreboard bench for maxnet_controller with a table-driven PU stub. Each run
// pushes its predicted outcome when start is driven; the entry is popped and
// compared when done rises.
// -----------------------------------------------------------------------------
module tb_maxnet_controller;

    localparam int TB_MAX_ITER = 3;

    typedef struct {
        int              off;
        logic [1:0]      w;
        logic [4:0]      wv;
        logic [7:0]      it;
        logic            nw;
        logic            to;
        logic [3:0][4:0] fx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxnet_if #(.DW(5), .N(4), .ITW(8)) bus ();

    maxnet_controller #(
        .DW(5), .N(4), .MAX_ITER(TB_MAX_ITER), .ITW(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [3:0]      rs [16];
    logic [3:0][4:0] ro [16];
    logic [3:0][4:0] cur_x = '0;
    int mult_cnt = 0, sum_cnt = 0, mult_base = 0, sum_base = 0;
    logic [3:0][4:0] stub_out = '0;
    logic [3:0]      stub_s   = '0;
    logic [3:0][4:0] px_m     = '0;
    logic            prev_mult = 1'b0;

    assign bus.pu_out = stub_out;
    assign bus.pu_s   = stub_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // PU stub: the sum register loads the next table row on each ld_sum edge.
    always @(posedge clk) begin : stub
        int idx;
        idx = sum_cnt - sum_base;
        if (idx < 0) idx = 0;
        if (idx > 15) idx = 15;
        if (bus.ld_mult) mult_cnt <= mult_cnt + 1;
        if (bus.ld_sum) begin
            sum_cnt  <= sum_cnt + 1;
            stub_out <= ro[idx];
            stub_s   <= rs[idx];
        end
    end

    // Strobe protocol and pu_x stability, checked mid-cycle.
    always @(negedge clk) begin : mon
        int k;
        if (rst) begin
            k = mult_cnt - mult_base;
            if (k < 0) k = 0;
            if (k > 15) k = 15;
            if (bus.ld_mult) begin
                chk("strobe_overlap", 32'(bus.ld_sum), 32'd0);
                chk("px_in_mult", 32'(bus.pu_x), (k == 0) ? 32'(cur_x) : 32'(ro[k-1]));
                px_m <= bus.pu_x;
            end
            if (bus.ld_sum) begin
                chk("sum_after_mult", 32'(prev_mult), 32'd1);
                chk("px_in_sum", 32'(bus.pu_x), 32'(px_m));
            end
            prev_mult <= bus.ld_mult;
        end
    end

    function automatic exp_t model();
        exp_t e;
        e.w = '0; e.wv = '0; e.nw = 1'b0; e.to = 1'b0; e.it = '0; e.off = 0; e.fx = '0;
        for (int k = 0; k < 16; k++) begin
            int cnt;
            cnt  = $countones(rs[k]);
            e.it = 8'(k + 1);
            e.fx = ro[k];
            e.off = 3 * (k + 1) + 2;
            if (cnt == 1) begin
                for (int i = 3; i >= 0; i--) if (rs[k][i]) e.w = 2'(i);
                e.wv = ro[k][e.w];
                break;
            end
            if (cnt == 0) begin
                e.nw = 1'b1;
                break;
            end
            if (k + 1 == TB_MAX_ITER) begin
                e.nw = 1'b1;
                e.to = 1'b1;
                break;
            end
        end
        return e;
    endfunction

    task automatic set_resp(input int k, input logic [3:0] s, input logic [3:0][4:0] o);
        rs[k] = s;
        ro[k] = o;
    endtask

    task automatic clear_resp();
        for (int k = 0; k < 16; k++) begin
            rs[k] = 4'b1111;
            ro[k] = {5'd1, 5'd1, 5'd1, 5'd1};
        end
    endtask

    task automatic drive_start(input logic [3:0][4:0] x);
        @(negedge clk);
        cur_x      = x;
        mult_base  = mult_cnt;
        sum_base   = sum_cnt;
        bus.x_in   = x;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.x_in   = '1;
    endtask

    // inject_at: offset (edges after the start edge) at which a one-cycle
    // start pulse is raised; 0 means none.
    task automatic run_case(input string name, input logic [3:0][4:0] x, input int inject_at);
        exp_t e;
        int got;
        sb.push_back(model());
        drive_start(x);
        chk({name, "_start_busy"}, 32'(bus.busy), 32'd1);
        chk({name, "_start_done"}, 32'(bus.done), 32'd0);
        chk({name, "_start_iter"}, 32'(bus.iter_cnt), 32'd0);
        chk({name, "_start_res"}, {bus.winner, bus.winner_val, bus.no_winner, bus.timeout}, 32'd0);
        chk({name, "_start_px"}, 32'(bus.pu_x), 32'(x));
        got = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            bus.start = (c == inject_at);
            if (bus.done) begin
                got = c;
                break;
            end
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        if (got == 0) begin
            chk({name, "_done_seen"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_done_edge"}, 32'(got), 32'(e.off));
            chk({name, "_winner"}, 32'(bus.winner), 32'(e.w));
            chk({name, "_winner_val"}, 32'(bus.winner_val), 32'(e.wv));
            chk({name, "_iter_cnt"}, 32'(bus.iter_cnt), 32'(e.it));
            chk({name, "_no_winner"}, 32'(bus.no_winner), 32'(e.nw));
            chk({name, "_timeout"}, 32'(bus.timeout), 32'(e.to));
            chk({name, "_final_px"}, 32'(bus.pu_x), 32'(e.fx));
            chk({name, "_mult_pulses"}, 32'(mult_cnt - mult_base), 32'(e.it));
            chk({name, "_sum_pulses"}, 32'(sum_cnt - sum_base), 32'(e.it));
            chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
            @(posedge clk);
            #1;
            chk({name, "_done_hold"}, {bus.done, bus.busy}, 32'b10);
        end
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = '0;
        clear_resp();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {bus.done, bus.busy, bus.ld_mult, bus.ld_sum,
                          bus.no_winner, bus.timeout, bus.winner}, 32'd0);
        chk("rst_px", 32'(bus.pu_x), 32'd0);
        chk("rst_iter", 32'(bus.iter_cnt), 32'd0);
        chk("rst_wval", 32'(bus.winner_val), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_start", {bus.busy, bus.done}, 32'd0);

        // Two-iteration win, with a start pulse during the first SUM.
        clear_resp();
        set_resp(0, 4'b0110, {5'd0, 5'd4, 5'd5, 5'd0});
        set_resp(1, 4'b0100, {5'd0, 5'd3, 5'd0, 5'd0});
        run_case("win2", {5'd4, 5'd6, 5'd7, 5'd2}, 2);

        // All lanes die in the first iteration.
        clear_resp();
        set_resp(0, 4'b0000, '0);
        run_case("alldie", {5'd3, 5'd3, 5'd3, 5'd3}, 0);

        // Iteration cap reached with all lanes alive.
        clear_resp();
        set_resp(0, 4'b1111, {5'h1F, 5'd2, 5'd3, 5'd4});
        set_resp(1, 4'b1111, {5'h1E, 5'd1, 5'd2, 5'd3});
        set_resp(2, 4'b1111, {5'h1D, 5'd1, 5'd1, 5'd2});
        run_case("timeout", {5'd5, 5'd6, 5'd7, 5'd8}, 0);

        // Restart from DONE with a one-hot input; start collides with the
        // terminating UPDATE and must not be latched.
        clear_resp();
        set_resp(0, 4'b1000, {5'd1, 5'd0, 5'd0, 5'd0});
        run_case("restart", {5'd1, 5'd0, 5'd0, 5'd0}, 3);

        // Single survivor in lane 0 with a negative activation.
        clear_resp();
        set_resp(0, 4'b1011, {5'd2, 5'd0, 5'd1, 5'h1C});
        set_resp(1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'h1C});
        run_case("lane0neg", {5'd9, 5'd0, 5'd4, 5'h1A}, 0);

        // Asynchronous reset while ld_mult is high.
        clear_resp();
        drive_start({5'd7, 5'd7, 5'd7, 5'd7});
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.ld_mult) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("abort_saw_mult", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_strobes", {bus.ld_mult, bus.ld_sum, bus.busy, bus.done}, 32'd0);
        chk("abort_px", 32'(bus.pu_x), 32'd0);
        chk("abort_iter", 32'(bus.iter_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_idle", {bus.busy, bus.done, bus.ld_mult}, 32'd0);

        // Normal run after the abort.
        clear_resp();
        set_resp(0, 4'b0010, {5'd0, 5'd0, 5'd6, 5'd0});
        run_case("post_abort", {5'd2, 5'd4, 5'd8, 5'd1}, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
